matrix_bank: RTL

MATRIX_BANK -- requirements
Module: matrix_bank

---
 rtl/matrix_pkg.sv | 15 +
 rtl/matrix_bank_if.sv | 46 ++++
 rtl/matrix_row_mux.sv | 28 ++
 rtl/matrix_bank.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and width helpers for the matrix bank.
package matrix_pkg;

    // Controller states: normal operation, or zeroing one layer row by row.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Index width for a range of n entries, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_bank_if.sv
// Request/response bundle for the matrix bank: write port, read port, clear port.
interface matrix_bank_if
    import matrix_pkg::*;
#(
    parameter int SIZE      = 3,
    parameter int DATA_SIZE = 16,
    parameter int MAX_LAYER = 5
);
    localparam int IDX_W   = clog2_min1(SIZE);
    localparam int LAYER_W = clog2_min1(MAX_LAYER);
    localparam int ROW_W   = SIZE * DATA_SIZE;

    logic               write_valid;
    logic               write_ready;
    logic [LAYER_W-1:0] write_layer_index;
    logic [IDX_W-1:0]   write_row_index;
    logic [ROW_W-1:0]   write_data;

    logic               read_valid_in;
    logic               read_ready;
    logic [LAYER_W-1:0] read_layer_index;
    logic [IDX_W-1:0]   read_index;
    logic               read_column;
    logic [ROW_W-1:0]   read_data;
    logic               read_valid;

    logic               clear_req;
    logic [LAYER_W-1:0] clear_layer_index;
    logic               busy;
    logic               index_error;

    modport master (
        output write_valid, write_layer_index, write_row_index, write_data,
        output read_valid_in, read_layer_index, read_index, read_column,
        output clear_req, clear_layer_index,
        input  write_ready, read_ready, read_data, read_valid, busy, index_error
    );

    modport slave (
        input  write_valid, write_layer_index, write_row_index, write_data,
        input  read_valid_in, read_layer_index, read_index, read_column,
        input  clear_req, clear_layer_index,
        output write_ready, read_ready, read_data, read_valid, busy, index_error
    );

endinterface

// File: rtl/matrix_row_mux.sv
// Selects one row, or gathers one column, out of a single stored layer.
module matrix_row_mux
    import matrix_pkg::*;
#(
    parameter int SIZE      = 3,
    parameter int DATA_SIZE = 16,
    parameter int IDX_W     = clog2_min1(SIZE)
) (
    input  logic [SIZE-1:0][SIZE*DATA_SIZE-1:0] rows_i,
    input  logic [IDX_W-1:0]                    index_i,
    input  logic                                column_i,
    output logic [SIZE*DATA_SIZE-1:0]           data_o
);

    // Element k of the result comes from row k at the requested column; element 0 sits at the MSB.
    always_comb begin
        data_o = '0;
        if (!column_i) begin
            data_o = rows_i[index_i];
        end else begin
            for (int k = 0; k < SIZE; k++) begin
                data_o[(SIZE-k)*DATA_SIZE-1 -: DATA_SIZE] =
                    rows_i[k][(SIZE-int'(index_i))*DATA_SIZE-1 -: DATA_SIZE];
            end
        end
    end

endmodule

// File: rtl/matrix_bank.sv
// Bank of MAX_LAYER square matrices with row writes, row/column reads and per-layer clear.
module matrix_bank
    import matrix_pkg::*;
#(
    parameter int SIZE      = 3,
    parameter int DATA_SIZE = 16,
    parameter int MAX_LAYER = 5
) (
    input  logic          clk,
    input  logic          rst,
    matrix_bank_if.slave  bus
);
    localparam int IDX_W   = clog2_min1(SIZE);
    localparam int LAYER_W = clog2_min1(MAX_LAYER);
    localparam int ROW_W   = SIZE * DATA_SIZE;
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(SIZE - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   clr_row_q, clr_row_d;
    logic [LAYER_W-1:0] clr_layer_q, clr_layer_d;
    logic               rd_valid_q, rd_valid_d;
    logic [ROW_W-1:0]   rd_data_q, rd_data_d;
    logic               idx_err_q, idx_err_d;

    // Storage is deliberately left without reset; contents are defined only once written or cleared.
    logic [SIZE-1:0][ROW_W-1:0] mem_q [MAX_LAYER];

    logic               in_idle;
    logic               clear_fire, clear_ok;
    logic               write_fire, write_ok;
    logic               read_fire, read_ok;
    logic               rd_layer_ok, rd_index_ok;
    logic [LAYER_W-1:0] rd_layer_safe;
    logic [IDX_W-1:0]   rd_index_safe;
    logic [ROW_W-1:0]   mux_data;

    assign in_idle    = (state_q == IDLE);
    assign clear_fire = in_idle && bus.clear_req;
    assign clear_ok   = int'(bus.clear_layer_index) < MAX_LAYER;
    // A pending clear always takes priority over a write in the same cycle.
    assign write_fire = bus.write_valid && in_idle && !bus.clear_req;
    assign write_ok   = (int'(bus.write_layer_index) < MAX_LAYER) &&
                        (int'(bus.write_row_index) < SIZE);
    assign read_fire  = bus.read_valid_in && in_idle;
    assign rd_layer_ok = int'(bus.read_layer_index) < MAX_LAYER;
    assign rd_index_ok = int'(bus.read_index) < SIZE;
    assign read_ok    = rd_layer_ok && rd_index_ok;

    // Out-of-range requests are steered to entry 0 so the mux never indexes past the array.
    assign rd_layer_safe = rd_layer_ok ? bus.read_layer_index : '0;
    assign rd_index_safe = rd_index_ok ? bus.read_index : '0;

    matrix_row_mux #(
        .SIZE      (SIZE),
        .DATA_SIZE (DATA_SIZE),
        .IDX_W     (IDX_W)
    ) u_row_mux (
        .rows_i   (mem_q[rd_layer_safe]),
        .index_i  (rd_index_safe),
        .column_i (bus.read_column),
        .data_o   (mux_data)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: enter CLEAR on a valid clear, leave after the last row is zeroed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clear_fire && clear_ok) state_d = CLEAR;
            CLEAR:   if (clr_row_q == LAST_ROW) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshakes and busy flag.
    always_comb begin
        bus.busy        = (state_q == CLEAR);
        bus.read_ready  = in_idle;
        bus.write_ready = in_idle && !bus.clear_req;
    end

    // Clear sequencer next state: latch the target layer, then walk rows 0..SIZE-1.
    always_comb begin
        clr_row_d   = clr_row_q;
        clr_layer_d = clr_layer_q;
        if (clear_fire && clear_ok) begin
            clr_row_d   = '0;
            clr_layer_d = bus.clear_layer_index;
        end else if (state_q == CLEAR) begin
            clr_row_d = clr_row_q + 1'b1;
        end
    end

    // Clear sequencer registers; a reset abandons any clear in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_row_q   <= '0;
            clr_layer_q <= '0;
        end else begin
            clr_row_q   <= clr_row_d;
            clr_layer_q <= clr_layer_d;
        end
    end

    // Read response and error pulse next state; read_data holds between reads.
    always_comb begin
        rd_valid_d = read_fire;
        rd_data_d  = rd_data_q;
        if (read_fire) rd_data_d = read_ok ? mux_data : '0;
        idx_err_d  = (read_fire && !read_ok) || (write_fire && !write_ok) ||
                     (clear_fire && !clear_ok);
    end

    // Read response and error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            idx_err_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            idx_err_q  <= idx_err_d;
        end
    end

    // Storage update: clear row or accepted write; the read path samples the old contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_q[clr_layer_q][clr_row_q] <= '0;
            end else if (write_fire && write_ok) begin
                mem_q[bus.write_layer_index][bus.write_row_index] <= bus.write_data;
            end
        end
    end

    assign bus.read_data   = rd_data_q;
    assign bus.read_valid  = rd_valid_q;
    assign bus.index_error = idx_err_q;

endmodule
